// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, issues one imem request at a time,
// applies redirects, hands {inst, pc} to decode. Optional FETCH_PERF_EN counters.
// Ports: clk, reset (async active-low), PCSrc_F/PCBranch_F redirect,
//   imem_req/imem_addr_F/imem_ready/imem_rvalid/imem_rdata memory side,
//   stall_D/inst_valid_D/inst_D/pc_D decode side,
//   fetch_cnt/redirect_cnt/stall_cnt when FETCH_PERF_EN is defined.
module fetch_sequencer #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc_F,
  input  logic [ADDR_W-1:0] PCBranch_F,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr_F,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall_D,
  output logic              inst_valid_D,
  output logic [INST_W-1:0] inst_D,
`ifdef FETCH_PERF_EN
  output logic [ADDR_W-1:0] pc_D,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       redirect_cnt,
  output logic [31:0]       stall_cnt
`else
  output logic [ADDR_W-1:0] pc_D
`endif
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_nx;
  logic              drop_q, drop_nx;
  logic [INST_W-1:0] skid_q, skid_nx;
  logic              vld_nx;
  logic [INST_W-1:0] inst_nx;
  logic [ADDR_W-1:0] pcd_nx;
  logic              slot_free;

  assign imem_req    = reset && (state_q == ISSUE);
  assign imem_addr_F = pc_q;
  assign slot_free   = !inst_valid_D || !stall_D;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ISSUE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      skid_q       <= '0;
      inst_valid_D <= 1'b0;
      inst_D       <= '0;
      pc_D         <= '0;
    end else begin
      state_q      <= state_nx;
      pc_q         <= pc_nx;
      drop_q       <= drop_nx;
      skid_q       <= skid_nx;
      inst_valid_D <= vld_nx;
      inst_D       <= inst_nx;
      pc_D         <= pcd_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    pc_nx    = pc_q;
    drop_nx  = drop_q;
    skid_nx  = skid_q;
    vld_nx   = inst_valid_D;
    inst_nx  = inst_D;
    pcd_nx   = pc_D;
    if (inst_valid_D && !stall_D)
      vld_nx = 1'b0;
    unique case (state_q)
      ISSUE: begin
        if (imem_ready)
          state_nx = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_nx  = 1'b0;
            state_nx = ISSUE;
          end else if (slot_free) begin
            vld_nx   = 1'b1;
            inst_nx  = imem_rdata;
            pcd_nx   = pc_q;
            pc_nx    = pc_q + ADDR_W'(4);
            state_nx = ISSUE;
          end else begin
            skid_nx  = imem_rdata;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_D) begin
          vld_nx   = 1'b1;
          inst_nx  = skid_q;
          pcd_nx   = pc_q;
          pc_nx    = pc_q + ADDR_W'(4);
          state_nx = ISSUE;
        end
      end
      default: state_nx = ISSUE;
    endcase
    if (PCSrc_F) begin
      pc_nx   = PCBranch_F;
      vld_nx  = 1'b0;
      skid_nx = '0;
      // a request still in flight must be absorbed before issuing again
      if ((state_q == WAIT && !imem_rvalid) ||
          (state_q == ISSUE && imem_ready)) begin
        state_nx = WAIT;
        drop_nx  = 1'b1;
      end else begin
        state_nx = ISSUE;
        drop_nx  = 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic deliver;
  assign deliver = !PCSrc_F &&
    ((state_q == WAIT && imem_rvalid && !drop_q && slot_free) ||
     (state_q == HOLD && !stall_D));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (deliver && fetch_cnt != '1)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (PCSrc_F && redirect_cnt != '1)
        redirect_cnt <= redirect_cnt + 32'd1;
      if (inst_valid_D && stall_D && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed bursts, redirect,
// stall/HOLD, ready backpressure, and PC wrap on a second instance.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc_F = 1'b0;
  logic [63:0] PCBranch_F = '0;
  logic        imem_req;
  logic [63:0] imem_addr_F;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_D = 1'b0;
  logic        inst_valid_D;
  logic [31:0] inst_D;
  logic [63:0] pc_D;

  logic        req_w;
  logic [63:0] addr_w;
  logic        rvalid_w = 1'b0;
  logic [31:0] rdata_w = '0;
  logic        vld_w;
  logic [31:0] inst_w;
  logic [63:0] pcd_w;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, redirect_cnt, stall_cnt;
  logic [31:0] fetch_cnt_w, redirect_cnt_w, stall_cnt_w;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset),
    .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
    .imem_req(imem_req), .imem_addr_F(imem_addr_F),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .stall_D(stall_D),
    .inst_valid_D(inst_valid_D), .inst_D(inst_D),
`ifdef FETCH_PERF_EN
    .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt),
    .stall_cnt(stall_cnt),
`endif
    .pc_D(pc_D)
  );

  fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset),
    .PCSrc_F(1'b0), .PCBranch_F(64'd0),
    .imem_req(req_w), .imem_addr_F(addr_w),
    .imem_ready(1'b1), .imem_rvalid(rvalid_w),
    .imem_rdata(rdata_w), .stall_D(1'b0),
    .inst_valid_D(vld_w), .inst_D(inst_w),
`ifdef FETCH_PERF_EN
    .fetch_cnt(fetch_cnt_w), .redirect_cnt(redirect_cnt_w),
    .stall_cnt(stall_cnt_w),
`endif
    .pc_D(pcd_w)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] next_pc = '0;
  int          lat = 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc);
    exp_t e;
    e.pc = pc;
    e.inst = mem_word(pc);
    q.push_back(e);
    next_pc = pc + 64'd4;
  endtask

  // memory model for the main instance
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [63:0] pend_addr = '0;
  always @(negedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (!reset) pend = 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend = 1'b0;
      end else cnt--;
    end
    if (imem_req && imem_ready) begin
      pend = 1'b1;
      pend_addr = imem_addr_F;
      cnt = lat;
    end
  end

  // memory model for the wrap instance, always ready, 1-cycle latency
  logic        pend_w = 1'b0;
  logic [63:0] paddr_w = '0;
  always @(negedge clk) begin
    #1;
    rvalid_w = 1'b0;
    if (!reset) pend_w = 1'b0;
    if (pend_w) begin
      rvalid_w = 1'b1;
      rdata_w = mem_word(paddr_w);
      pend_w = 1'b0;
    end
    if (req_w) begin
      pend_w = 1'b1;
      paddr_w = addr_w;
    end
  end

  // monitor: main instance handoffs and hold stability
  logic        held = 1'b0;
  logic [63:0] held_pc;
  logic [31:0] held_inst;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      if (held) begin
        chk("hold_vld", {63'd0, inst_valid_D}, 64'd1);
        chk("hold_pc", pc_D, held_pc);
        chk("hold_inst", {32'd0, inst_D}, {32'd0, held_inst});
      end
      if (inst_valid_D && !stall_D) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out got=%h want=none", pc_D);
        end else begin
          e = q.pop_front();
          chk("out_pc", pc_D, e.pc);
          chk("out_inst", {32'd0, inst_D}, {32'd0, e.inst});
        end
      end
      held = inst_valid_D && stall_D;
      held_pc = pc_D;
      held_inst = inst_D;
    end else held = 1'b0;
  end

  // monitor: wrap instance, first four deliveries
  logic [63:0] w_next = 64'hFFFF_FFFF_FFFF_FFFC;
  int          w_seen = 0;
  always @(negedge clk) begin
    #2;
    if (reset && vld_w && w_seen < 4) begin
      chk("wrap_pc", pcd_w, w_next);
      chk("wrap_inst", {32'd0, inst_w}, {32'd0, mem_word(w_next)});
      w_next = w_next + 64'd4;
      w_seen++;
    end
  end

  task automatic burst(input int n);
    int k = 0;
    int cyc = 0;
    imem_ready = 1'b1;
    while (k < n && cyc < 50 * n) begin
      if (imem_req) begin
        chk("req_addr", imem_addr_F, next_pc);
        push(next_pc);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    if (k < n) chk("burst_timeout", 64'(k), 64'(n));
    imem_ready = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    imem_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_req", {63'd0, imem_req}, 64'd0);
    end
    chk("rst_vld", {63'd0, inst_valid_D}, 64'd0);
    chk("rst_pc_D", pc_D, 64'd0);
    chk("rst_inst_D", {32'd0, inst_D}, 64'd0);
    imem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr_F, 64'd0);

    burst(100);
    drain();
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", {32'd0, fetch_cnt}, 64'd100);
`endif

    lat = 3;
    imem_ready = 1'b1;
    cyc = 0;
    while (!imem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stale_addr", imem_addr_F, next_pc);
    @(negedge clk);
    imem_ready = 1'b0;
    lat = 1;
    PCSrc_F = 1'b1;
    PCBranch_F = 64'd69857;
    @(negedge clk);
    PCSrc_F = 1'b0;
    chk("drop_req", {63'd0, imem_req}, 64'd0);
    chk("drop_vld", {63'd0, inst_valid_D}, 64'd0);
    next_pc = 64'd69857;
    burst(3);
    drain();
`ifdef FETCH_PERF_EN
    chk("redirect_cnt", {32'd0, redirect_cnt}, 64'd1);
`endif

    stall_D = 1'b1;
    burst(2);
    repeat (2) @(negedge clk);
    chk("hold_req", {63'd0, imem_req}, 64'd0);
    chk("hold_q", 64'(q.size()), 64'd2);
    @(negedge clk);
    stall_D = 1'b0;
    drain();
    burst(3);
    drain();

    repeat (4) begin
      @(negedge clk);
      chk("bp_req", {63'd0, imem_req}, 64'd1);
      chk("bp_addr", imem_addr_F, next_pc);
    end
    burst(2);
    drain();

    chk("wrap_seen", 64'(w_seen), 64'd4);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
